ped_crossing_ctrl: RTL and testbench

//   Downstream consumer of the traffic-light sequencer's one-hot light[2:0] bus.

---
 rtl/ped_crossing_ctrl_if.sv | 42 ++++
 rtl/ped_crossing_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ped_crossing_ctrl_if.sv
// ---------------------------------------------------------------------------
// ped_crossing_ctrl_if
//   Signal bundle between the traffic-light side (master: drives the light
//   code and the push button, observes the lamps) and the pedestrian crossing
//   controller (slave).
//
//   light_i       [2:0]      one-hot light code: 001 green, 010 yellow,
//                            100 red, 000 idle
//   ped_btn_i                pedestrian push button (level)
//   walk_o                   walk lamp
//   dont_walk_o              don't-walk lamp (toggles during flashing clearance)
//   flash_o                  high throughout the flashing clearance phase
//   countdown_o   [CNT_W-1:0] cycles remaining in the current walk/flash phase
//   req_pending_o            latched, not yet served pedestrian request
//   abort_o                  one-cycle pulse: walk sequence cut short
//   fault_o                  high while the controller is in its fault state
// ---------------------------------------------------------------------------
interface ped_crossing_ctrl_if #(
  parameter int CNT_W = 4
);
  logic [2:0]       light_i;
  logic             ped_btn_i;
  logic             walk_o;
  logic             dont_walk_o;
  logic             flash_o;
  logic [CNT_W-1:0] countdown_o;
  logic             req_pending_o;
  logic             abort_o;
  logic             fault_o;

  modport master (
    output light_i, ped_btn_i,
    input  walk_o, dont_walk_o, flash_o, countdown_o,
           req_pending_o, abort_o, fault_o
  );

  modport slave (
    input  light_i, ped_btn_i,
    output walk_o, dont_walk_o, flash_o, countdown_o,
           req_pending_o, abort_o, fault_o
  );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// ---------------------------------------------------------------------------
// ped_crossing_ctrl
//   Pedestrian crossing controller sitting downstream of the traffic-light
//   sequencer. Grants a WALK window only on the edge that first sees red
//   (with a request pending), follows it with a flashing clearance phase and
//   returns to DON'T WALK. Any multi-hot light code forces a safe FAULT state
//   that is left only once green is seen again.
//
// Ports
//   clk   rising-edge clock shared with the light sequencer
//   rst   asynchronous, active-high reset
//   bus   ped_crossing_ctrl_if.slave (light/button in, lamps and status out)
//
// Parameters
//   WALK_CYC   cycles the walk lamp is held     (1 .. 2**CNT_W)
//   FLASH_CYC  cycles of flashing clearance     (1 .. 2**CNT_W)
//   CNT_W      width of the countdown register
//
// Build option
//   PED_AUTO_WALK_EN  when defined, every red rising edge seen in STOP starts
//                     a walk cycle without a request; the request latch still
//                     sets and clears exactly as in the default build.
// ---------------------------------------------------------------------------
module ped_crossing_ctrl #(
  parameter int WALK_CYC  = 5,
  parameter int FLASH_CYC = 3,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ped_crossing_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_WALK  = 2'd1,
    ST_FLASH = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [2:0]       LIGHT_GREEN = 3'b001;
  localparam logic [2:0]       LIGHT_RED   = 3'b100;
  // Countdown is loaded with N-1 so that 0 is the last cycle of the phase.
  localparam logic [CNT_W-1:0] WALK_LOAD   = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD  = CNT_W'(FLASH_CYC - 1);

`ifdef PED_AUTO_WALK_EN
  localparam logic AUTO_WALK = 1'b1;
`else
  localparam logic AUTO_WALK = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [2:0]       prev_light_q;
  logic [CNT_W-1:0] countdown_q, countdown_d;
  logic             req_pending_q, req_pending_d;
  logic             walk_q, walk_d;
  logic             dont_walk_q, dont_walk_d;
  logic             flash_q, flash_d;
  logic             abort_q, abort_d;
  logic             fault_q, fault_d;

  logic illegal;
  logic red_rise;
  logic walk_req;

  // x & (x-1) clears the lowest set bit; anything left means two or more
  // lamps are lit at once.
  assign illegal  = |(bus.light_i & (bus.light_i - 3'd1));
  assign red_rise = (bus.light_i == LIGHT_RED) && (prev_light_q != LIGHT_RED);
  assign walk_req = req_pending_q | bus.ped_btn_i | AUTO_WALK;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    countdown_d   = countdown_q;
    req_pending_d = req_pending_q;
    walk_d        = 1'b0;
    dont_walk_d   = 1'b1;
    flash_d       = 1'b0;
    abort_d       = 1'b0;
    fault_d       = 1'b0;

    if (illegal) begin
      // Highest priority in every state; also suppresses any abort pulse.
      state_d       = ST_FAULT;
      countdown_d   = '0;
      req_pending_d = 1'b0;
      fault_d       = 1'b1;
    end else begin
      unique case (state_q)
        ST_STOP: begin
          countdown_d = '0;
          if (red_rise && walk_req) begin
            state_d       = ST_WALK;
            countdown_d   = WALK_LOAD;
            req_pending_d = 1'b0;
            walk_d        = 1'b1;
            dont_walk_d   = 1'b0;
          end else begin
            req_pending_d = req_pending_q | bus.ped_btn_i;
          end
        end

        ST_WALK: begin
          if (bus.light_i != LIGHT_RED) begin
            state_d     = ST_STOP;
            countdown_d = '0;
            abort_d     = 1'b1;
          end else if (countdown_q == '0) begin
            state_d     = ST_FLASH;
            countdown_d = FLASH_LOAD;
            flash_d     = 1'b1;
          end else begin
            countdown_d = countdown_q - 1'b1;
            walk_d      = 1'b1;
            dont_walk_d = 1'b0;
          end
        end

        ST_FLASH: begin
          if (bus.light_i != LIGHT_RED) begin
            state_d     = ST_STOP;
            countdown_d = '0;
            abort_d     = 1'b1;
          end else if (countdown_q == '0) begin
            state_d     = ST_STOP;
          end else begin
            // First flash cycle was entered with dont_walk=1 from WALK.
            countdown_d = countdown_q - 1'b1;
            flash_d     = 1'b1;
            dont_walk_d = ~dont_walk_q;
          end
        end

        ST_FAULT: begin
          countdown_d   = '0;
          req_pending_d = 1'b0;
          if (bus.light_i == LIGHT_GREEN) begin
            state_d = ST_STOP;
          end else begin
            fault_d = 1'b1;
          end
        end

        default: begin
          state_d     = ST_STOP;
          countdown_d = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_STOP;
      prev_light_q  <= 3'b000;
      countdown_q   <= '0;
      req_pending_q <= 1'b0;
      walk_q        <= 1'b0;
      dont_walk_q   <= 1'b1;
      flash_q       <= 1'b0;
      abort_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_light_q  <= bus.light_i;
      countdown_q   <= countdown_d;
      req_pending_q <= req_pending_d;
      walk_q        <= walk_d;
      dont_walk_q   <= dont_walk_d;
      flash_q       <= flash_d;
      abort_q       <= abort_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.walk_o        = walk_q;
  assign bus.dont_walk_o   = dont_walk_q;
  assign bus.flash_o       = flash_q;
  assign bus.countdown_o   = countdown_q;
  assign bus.req_pending_o = req_pending_q;
  assign bus.abort_o       = abort_q;
  assign bus.fault_o       = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ped_crossing_ctrl
//   Self-checking bench for ped_crossing_ctrl. A behavioural model tracks the
//   crossing as "stopped", "active for N cycles since walk began" or
//   "faulted"; lamp values and the countdown are derived arithmetically from
//   the elapsed cycle count. A compare process checks every cycle, and a set
//   of directed sequences pins the model with literal expectations before a
//   randomized sweep of light codes and button presses.
// ---------------------------------------------------------------------------
module tb_ped_crossing_ctrl;

  localparam int W     = 5;
  localparam int F     = 3;
  localparam int CNT_W = 4;
  localparam int OW    = CNT_W + 6;

  typedef logic [OW-1:0] ovec_t;
  typedef enum int {M_STOP, M_ACTIVE, M_FAULT} mmode_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   cmp_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  ped_crossing_ctrl_if #(.CNT_W(CNT_W)) bus ();

  ped_crossing_ctrl #(
    .WALK_CYC  (W),
    .FLASH_CYC (F),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  ovec_t dut_vec;
  assign dut_vec = {bus.walk_o, bus.dont_walk_o, bus.flash_o, bus.countdown_o,
                    bus.req_pending_o, bus.abort_o, bus.fault_o};

  function automatic ovec_t pack(bit w, bit dw, bit fl, int cd, bit rq, bit ab, bit ft);
    logic [CNT_W-1:0] c;
    c = CNT_W'(cd);
    return {w, dw, fl, c, rq, ab, ft};
  endfunction

  task automatic check(string name, ovec_t act, ovec_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b (walk,dw,flash,cd,req,abort,fault) t=%0t",
                  name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
`ifdef PED_AUTO_WALK_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  mmode_e     m_mode  = M_STOP;
  int         m_el    = 0;     // cycles since walk started
  bit         m_req   = 1'b0;
  bit         m_abort = 1'b0;
  logic [2:0] m_prev  = 3'b000;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= M_STOP;
      m_el    <= 0;
      m_req   <= 1'b0;
      m_abort <= 1'b0;
      m_prev  <= 3'b000;
    end else begin
      m_abort <= 1'b0;
      m_prev  <= bus.light_i;
      if ($countones(bus.light_i) > 1) begin
        m_mode <= M_FAULT;
        m_req  <= 1'b0;
      end else begin
        case (m_mode)
          M_STOP: begin
            if (bus.light_i == 3'b100 && m_prev != 3'b100 &&
                (m_req || bus.ped_btn_i || AUTO)) begin
              m_mode <= M_ACTIVE;
              m_el   <= 0;
              m_req  <= 1'b0;
            end else if (bus.ped_btn_i) begin
              m_req <= 1'b1;
            end
          end
          M_ACTIVE: begin
            if (bus.light_i != 3'b100) begin
              m_mode  <= M_STOP;
              m_abort <= 1'b1;
            end else begin
              m_el <= m_el + 1;
              if (m_el + 1 == W + F) m_mode <= M_STOP;
            end
          end
          M_FAULT: if (bus.light_i == 3'b001) m_mode <= M_STOP;
          default: m_mode <= M_STOP;
        endcase
      end
    end
  end

  function automatic ovec_t model_out();
    int f;
    case (m_mode)
      M_ACTIVE: begin
        if (m_el < W) return pack(1, 0, 0, W - 1 - m_el, 0, 0, 0);
        f = m_el - W;
        return pack(0, (f % 2) == 0, 1, F - 1 - f, 0, 0, 0);
      end
      M_FAULT: return pack(0, 1, 0, 0, 0, 0, 1);
      default: return pack(0, 1, 0, 0, m_req, m_abort, 0);
    endcase
  endfunction

  // Outputs change only at posedge (or async reset); sample at negedge.
  always @(negedge clk) begin
    if (cmp_en) check("cycle", dut_vec, model_out());
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [2:0] l, input logic b);
    @(negedge clk);
    bus.light_i   = l;
    bus.ped_btn_i = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(string name, bit w, bit dw, bit fl, int cd,
                            bit rq, bit ab, bit ft);
    check(name, dut_vec, pack(w, dw, fl, cd, rq, ab, ft));
  endtask

  function automatic logic [2:0] rand_light();
    int r;
    logic [2:0] bad [4];
    bad[0] = 3'b011; bad[1] = 3'b101; bad[2] = 3'b110; bad[3] = 3'b111;
    r = $urandom_range(0, 99);
    if (r < 30) return 3'b001;
    if (r < 45) return 3'b010;
    if (r < 85) return 3'b100;
    if (r < 90) return 3'b000;
    return bad[$urandom_range(0, 3)];
  endfunction

  initial begin
    logic [2:0] l;
    int hold;

    bus.light_i   = 3'b001;
    bus.ped_btn_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    expect_out("reset_values", 0, 1, 0, 0, 0, 0, 0);

    // 1: idle on green
    repeat (20) step(3'b001, 1'b0);
    expect_out("idle_green", 0, 1, 0, 0, 0, 0, 0);

    // 2: button on green, then yellow, then red -> full walk/flash cycle
    step(3'b001, 1'b1);
    expect_out("req_latch", 0, 1, 0, 0, 1, 0, 0);
    step(3'b001, 1'b0);
    step(3'b010, 1'b0);
    expect_out("req_hold_yellow", 0, 1, 0, 0, 1, 0, 0);
    step(3'b100, 1'b0);
    expect_out("walk_start", 1, 0, 0, 4, 0, 0, 0);
    for (int i = 1; i < 5; i++) begin
      step(3'b100, 1'b0);
      expect_out("walk_count", 1, 0, 0, 4 - i, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(3'b100, 1'b0);
      expect_out("flash_phase", 0, (i % 2) == 0, 1, 2 - i, 0, 0, 0);
    end
    step(3'b100, 1'b0);
    expect_out("back_to_stop", 0, 1, 0, 0, 0, 0, 0);

    // 3: green during walk -> one-cycle abort; button on abort edge ignored
    step(3'b001, 1'b1);
    step(3'b100, 1'b0);
    step(3'b100, 1'b0);
    step(3'b100, 1'b0);
    expect_out("walk_cd2", 1, 0, 0, 2, 0, 0, 0);
    step(3'b001, 1'b1);
    expect_out("abort_pulse", 0, 1, 0, 0, 0, 1, 0);
    step(3'b001, 1'b0);
    expect_out("abort_clear", 0, 1, 0, 0, 0, 0, 0);

    // 4: illegal code during walk -> FAULT until green
    step(3'b001, 1'b1);
    step(3'b100, 1'b0);
    step(3'b110, 1'b0);
    expect_out("fault_enter", 0, 1, 0, 0, 0, 0, 1);
    step(3'b100, 1'b1);
    expect_out("fault_hold_red", 0, 1, 0, 0, 0, 0, 1);
    step(3'b001, 1'b0);
    expect_out("fault_exit", 0, 1, 0, 0, 0, 0, 0);

`ifndef PED_AUTO_WALK_EN
    // 5: request arriving while already red waits for the next red edge
    step(3'b100, 1'b0);
    expect_out("red_no_req", 0, 1, 0, 0, 0, 0, 0);
    step(3'b100, 1'b1);
    expect_out("late_req", 0, 1, 0, 0, 1, 0, 0);
    step(3'b100, 1'b0);
    expect_out("late_req_wait", 0, 1, 0, 0, 1, 0, 0);
    step(3'b010, 1'b0);
    step(3'b001, 1'b0);
    step(3'b100, 1'b0);
    expect_out("late_req_walk", 1, 0, 0, 4, 0, 0, 0);
    repeat (8) step(3'b100, 1'b0);
    expect_out("late_req_done", 0, 1, 0, 0, 0, 0, 0);
`else
    // 6: auto walk at every red edge without any button
    for (int k = 0; k < 2; k++) begin
      step(3'b001, 1'b0);
      step(3'b010, 1'b0);
      step(3'b100, 1'b0);
      expect_out("auto_walk", 1, 0, 0, 4, 0, 0, 0);
      repeat (8) step(3'b100, 1'b0);
      expect_out("auto_done", 0, 1, 0, 0, 0, 0, 0);
    end
`endif

    // Asynchronous reset in the middle of FLASH
    step(3'b001, 1'b1);
    step(3'b100, 1'b0);
    repeat (5) step(3'b100, 1'b0);
    expect_out("pre_reset_flash", 0, 1, 1, 2, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_reset", 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) step(3'b100, 1'b0);

    // Randomized sweep
    for (int n = 0; n < 400; n++) begin
      l    = rand_light();
      hold = $urandom_range(1, 10);
      for (int h = 0; h < hold; h++) step(l, $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
